// File: rtl/mem_pkg.sv
// Shared types and helpers for memory-target blocks: the FSM state encoding,
// the width constants and the address-legality check.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int LAT_W  = 4;
    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // A word access is legal only when it is word-aligned and falls inside the array.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= (34'(depth) << 2));
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32-bit word storage.
// Writes are synchronous with per-byte-lane enables; reads are combinational.
module data_mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it would force a flop-based
    // implementation instead of a RAM, and contents after reset are undefined.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory target with a req/ready/ack handshake. It accepts one
// request at a time and completes it LATENCY edges after acceptance.
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,  // power of two
    parameter int unsigned LATENCY = 4      // 1..15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t            state, state_nxt;
    logic [LAT_W-1:0]  cnt;
    logic              lat_we;
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;
    logic              commit;
    logic              bad;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    assign ready_o = (state == IDLE);
    assign commit  = (state == BUSY) && (cnt == '0);
    assign bad     = addr_err(lat_addr, DEPTH);
    assign mem_we  = commit && lat_we && !bad;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default is assigned before the case so no path leaves
    // state_nxt unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_i)  state_nxt = BUSY;
            BUSY:    if (commit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            rdata_o   <= '0;
        end else if (state == IDLE) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            if (req_i) begin
                lat_we    <= we_i;
                lat_addr  <= addr_i;
                lat_wdata <= wdata_i;
                lat_be    <= be_i;
                cnt       <= LAT_W'(LATENCY - 1);
            end
        end else if (!commit) begin
            cnt <= cnt - 1'b1;
        end else begin
            // Commit edge: a rejected access only reports the error.
            ack_o <= 1'b1;
            err_o <= bad;
            if (!bad && !lat_we) begin
                rdata_o <= mem_rdata;
            end
        end
    end

    data_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk_i),
        .we    (mem_we),
        .be    (lat_be),
        .idx   (lat_addr[IDX_W+1:2]),
        .wdata (lat_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: instance 0 has LATENCY=4,
// instance 1 has LATENCY=1 and instance 2 has LATENCY=15.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  be    [3];
    logic        ready [3];
    logic        ack   [3];
    logic        err   [3];
    logic [31:0] rdata [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int lat_of [3];

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH(1024), .LATENCY(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .be_i(be[0]), .ready_o(ready[0]), .ack_o(ack[0]),
        .rdata_o(rdata[0]), .err_o(err[0]));

    data_memory_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .be_i(be[1]), .ready_o(ready[1]), .ack_o(ack[1]),
        .rdata_o(rdata[1]), .err_o(err[1]));

    data_memory_responder #(.DEPTH(1024), .LATENCY(15)) u_dut15 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
        .wdata_i(wdata[2]), .be_i(be[2]), .ready_o(ready[2]), .ack_o(ack[2]),
        .rdata_o(rdata[2]), .err_o(err[2]));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue one request and follow it through to its ack, measuring the handshake.
    task automatic access(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output int lat, output int low, output logic rdy_ack,
                          output logic e, output logic [31:0] rd, output logic ack_after,
                          output int leak);
        lat = -1; low = 0; rdy_ack = 1'b0; e = 1'b0; rd = '0; ack_after = 1'b1; leak = 0;
        @(negedge clk);
        for (int k = 0; k < 50 && !ready[s]; k++) @(negedge clk);
        req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d; be[s] = b;
        @(posedge clk);
        #1 req[s] = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (ack[s]) begin
                lat = i; e = err[s]; rd = rdata[s]; rdy_ack = ready[s];
                break;
            end
            if (err[s]) leak++;
            if (!ready[s]) low++;
        end
        @(posedge clk);
        #1 ack_after = ack[s];
    endtask

    task automatic run_check(input string name, input int s, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] b, input logic exp_e,
                             input logic [31:0] exp_rd);
        int lat, low, leak;
        logic rdy_ack, e, ack_after;
        logic [31:0] rd;
        access(s, w, a, d, b, lat, low, rdy_ack, e, rd, ack_after, leak);
        check({name, " latency"}, lat, lat_of[s]);
        check({name, " ready-low cycles"}, low, lat_of[s]);
        check({name, " ready in ack cycle"}, 32'(rdy_ack), 1);
        check({name, " err"}, 32'(e), 32'(exp_e));
        check({name, " rdata"}, rd, exp_rd);
        check({name, " ack one cycle"}, 32'(ack_after), 0);
        check({name, " err without ack"}, leak, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int got, n_ack;

        lat_of = '{4, 1, 15};
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b0, 32'hDEAD_BEAA};
        vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'b1111, 1'b1, 32'hDEAD_BEAA};
        vecs[5]  = '{1'b1, 32'h0000_0000, 32'h1111_2222, 4'b1111, 1'b0, 32'hDEAD_BEAA};
        vecs[6]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'hDEAD_BEAA};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b0, 32'h1111_2222};
        vecs[8]  = '{1'b1, 32'h0000_0030, 32'h55AA_55AA, 4'b1111, 1'b0, 32'h1111_2222};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h1111_2222};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b0, 32'hDEAD_BEAA};
        vecs[11] = '{1'b1, 32'h0000_0012, 32'h0000_0000, 4'b1111, 1'b1, 32'hDEAD_BEAA};
        vecs[12] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'b0000, 1'b1, 32'hDEAD_BEAA};
        vecs[13] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b0, 32'hDEAD_BEAA};

        for (int s = 0; s < 3; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0; be[s] = '0;
        end
        rst_i = 1'b0;
        #12;
        check("reset ready", 32'(ready[0]), 1);
        check("reset ack", 32'(ack[0]), 0);
        check("reset err", 32'(err[0]), 0);
        check("reset rdata", rdata[0], 0);
        @(negedge clk);
        rst_i = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_check($sformatf("vec%0d", i), 0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].be, vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Back-to-back: read raised in the write's ack cycle; BUSY-time req pulse is ignored.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h1234_5678; be[0] = 4'hF;
        @(posedge clk);
        #1 req[0] = 1'b0;
        got = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0; wdata[0] = 32'h0; be[0] = 4'hF;
            end
            if (i == 2) req[0] = 1'b0;
            if (ack[0]) begin
                got = i;
                break;
            end
        end
        check("b2b write latency", got, 4);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h20; be[0] = 4'h0;
        @(posedge clk);
        #1 req[0] = 1'b0;
        check("b2b read accepted in ack cycle", 32'(ready[0]), 0);
        got = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ack[0]) begin
                got = i;
                break;
            end
        end
        check("b2b read latency", got, 4);
        check("b2b read rdata", rdata[0], 32'h1234_5678);
        check("b2b read err", 32'(err[0]), 0);
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 if (ack[0]) n_ack++;
        end
        check("b2b no extra acks", n_ack, 0);
        run_check("ignored busy write", 0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h1111_2222);

        run_check("lat1 write", 1, 1'b1, 32'h40, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0);
        run_check("lat1 read", 1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'hA5A5_A5A5);
        run_check("lat15 write", 2, 1'b1, 32'h44, 32'h5A5A_1234, 4'hF, 1'b0, 32'h0);
        run_check("lat15 read", 2, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 32'h5A5A_1234);

        // Reset two edges after acceptance aborts the write.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hCAFE_F00D; be[0] = 4'hF;
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b0;
        #1;
        check("abort ready on reset", 32'(ready[0]), 1);
        check("abort ack on reset", 32'(ack[0]), 0);
        @(negedge clk);
        rst_i = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 if (ack[0]) n_ack++;
        end
        check("abort no ack", n_ack, 0);
        run_check("abort read 0x30", 0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h55AA_55AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
